// File: rtl/msi_bus_ctrl_if.sv
// Per-cache bus bundle between the cache controllers (master) and msi_bus_ctrl (slave).
// Request/op/addr/data/done fields are packed per cache: cache k owns slice k of each vector.
interface msi_bus_if #(
    parameter int N_CACHE = 2
);
    logic [N_CACHE-1:0]    req;
    logic [3*N_CACHE-1:0]  c_op;
    logic [5*N_CACHE-1:0]  c_addr;
    logic [16*N_CACHE-1:0] c_data;
    logic [N_CACHE-1:0]    c_done;
    logic [N_CACHE-1:0]    grant;
    logic [3*N_CACHE-1:0]  s_op;
    logic [4:0]            s_addr;
    logic [15:0]           s_data;
    logic [N_CACHE-1:0]    s_done;

    modport master (
        output req, c_op, c_addr, c_data, c_done,
        input  grant, s_op, s_addr, s_data, s_done
    );

    modport slave (
        input  req, c_op, c_addr, c_data, c_done,
        output grant, s_op, s_addr, s_data, s_done
    );
endinterface

// File: rtl/msi_bus_ctrl.sv
// MSI snooping bus arbiter plus 32 x 16-bit main memory responder.
// state    | meaning
// IDLE     | no grantee, round-robin arbitration on req
// GRANT    | waiting for the grantee's op (timeout on BusNone)
// SNOOP    | broadcast latched op/addr to non-grantees
// LISTEN   | watch non-grantees for a matching flush
// MEMRD    | memory access latency
// DONE     | s_done pulse with data to the grantee
// RELEASE  | drop grant, advance round-robin pointer
module msi_bus_ctrl #(
    parameter int N_CACHE    = 2,
    parameter int MEM_LAT    = 3,
    parameter int SNOOP_WIN  = 2,
    parameter int OP_TIMEOUT = 4
) (
    input  logic     clk,
    input  logic     reset,
    msi_bus_if.slave bus
);
    localparam int IW = (N_CACHE > 2) ? 2 : 1;
    localparam logic [2:0] OP_RD    = 3'd1;
    localparam logic [2:0] OP_UPGR  = 3'd2;
    localparam logic [2:0] OP_FLUSH = 3'd3;
    localparam logic [2:0] OP_RDX   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_SNOOP, S_LISTEN, S_MEMRD, S_DONE, S_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d, rr_q, rr_d;
    logic [2:0]             op_q, op_d;
    logic [4:0]             addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [N_CACHE-1:0]     grant_q, grant_d, s_done_q, s_done_d;
    logic [3*N_CACHE-1:0]   s_op_q, s_op_d;
    logic [4:0]             s_addr_q, s_addr_d;
    logic [15:0]            s_data_q, s_data_d;
    logic [15:0]            mem_q [32];

    logic                   mem_we;
    logic [4:0]             mem_wa;
    logic [15:0]            mem_wd;
    logic [2:0]             g_op;
    logic [4:0]             g_addr;
    logic [15:0]            g_data;
    logic                   fl_hit, hi_hit;
    logic [15:0]            fl_data;
    logic [IW-1:0]          hi_idx, lo_idx, pick_idx;

    assign g_op   = bus.c_op[3*idx_q +: 3];
    assign g_addr = bus.c_addr[5*idx_q +: 5];
    assign g_data = bus.c_data[16*idx_q +: 16];

    // Descending scans so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_hit  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        fl_hit  = 1'b0;
        fl_data = '0;
        for (int k = N_CACHE - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                lo_idx = IW'(k);
                if (IW'(k) >= rr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = IW'(k);
                end
            end
            if (IW'(k) != idx_q && bus.c_done[k] && bus.c_op[3*k +: 3] == OP_FLUSH &&
                bus.c_addr[5*k +: 5] == addr_q) begin
                fl_hit  = 1'b1;
                fl_data = bus.c_data[16*k +: 16];
            end
        end
        pick_idx = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = addr_q;
        mem_wd  = data_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    idx_d   = pick_idx;
                    cnt_d   = 4'(OP_TIMEOUT - 1);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (g_op == OP_FLUSH) begin
                    op_d    = OP_FLUSH;
                    addr_d  = g_addr;
                    mem_we  = 1'b1;
                    mem_wa  = g_addr;
                    mem_wd  = g_data;
                    state_d = S_DONE;
                end else if (g_op == OP_RD || g_op == OP_UPGR || g_op == OP_RDX) begin
                    op_d    = g_op;
                    addr_d  = g_addr;
                    state_d = S_SNOOP;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SNOOP: begin
                cnt_d   = 4'(SNOOP_WIN - 1);
                state_d = (op_q == OP_UPGR) ? S_DONE : S_LISTEN;
            end
            S_LISTEN: begin
                if (fl_hit) begin
                    data_d  = fl_data;
                    mem_we  = 1'b1;
                    mem_wd  = fl_data;
                    state_d = S_DONE;
                end else if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(MEM_LAT);
                    state_d = S_MEMRD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_MEMRD: begin
                // MEM_LAT cycles of access, then one cycle to latch the word.
                if (cnt_q == 4'd0) begin
                    data_d  = mem_q[addr_q];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:    state_d = S_RELEASE;
            S_RELEASE: begin
                rr_d    = (idx_q == IW'(N_CACHE - 1)) ? '0 : idx_q + 1'b1;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase

        // Outputs are registered from the state being entered.
        grant_d  = '0;
        s_op_d   = '0;
        s_done_d = '0;
        s_addr_d = '0;
        s_data_d = '0;
        if (state_d inside {S_GRANT, S_SNOOP, S_LISTEN, S_MEMRD, S_DONE})
            grant_d[idx_d] = 1'b1;
        if (state_d == S_SNOOP) begin
            for (int k = 0; k < N_CACHE; k++)
                if (IW'(k) != idx_d) s_op_d[3*k +: 3] = op_d;
        end
        if (state_d == S_SNOOP || state_d == S_DONE)
            s_addr_d = addr_d;
        if (state_d == S_DONE) begin
            s_done_d[idx_d] = 1'b1;
            if (op_d == OP_RD || op_d == OP_RDX) s_data_d = data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rr_q     <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            s_op_q   <= '0;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_done_q <= '0;
            for (int i = 0; i < 32; i++)
                mem_q[i] <= {2'b00, 5'(i), 1'b1, 2'b00, 5'(i), 1'b0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            s_op_q   <= s_op_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_done_q <= s_done_d;
            if (mem_we) mem_q[mem_wa] <= mem_wd;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.s_op   = s_op_q;
    assign bus.s_addr = s_addr_q;
    assign bus.s_data = s_data_q;
    assign bus.s_done = s_done_q;
endmodule

// File: tb/tb_msi_bus_ctrl.sv
// Bench for msi_bus_ctrl: a per-cycle expected-output timeline built from the bus timing rules,
// compared every cycle, plus literal spot checks on data, grant order and reset behaviour.
module tb_msi_bus_ctrl;
    localparam int NC = 2;
    localparam int ML = 3;
    localparam int SW = 2;
    localparam int TO = 4;
    localparam int MAXC = 1024;
    localparam int OP_NONE = 0, OP_RD = 1, OP_UPGR = 2, OP_FLUSH = 3, OP_RDX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    msi_bus_if #(.N_CACHE(NC)) bus ();

    msi_bus_ctrl #(.N_CACHE(NC), .MEM_LAT(ML), .SNOOP_WIN(SW), .OP_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [NC-1:0]   x_grant [MAXC];
    logic [3*NC-1:0] x_sop   [MAXC];
    logic [4:0]      x_saddr [MAXC];
    logic [15:0]     x_sdata [MAXC];
    logic [NC-1:0]   x_sdone [MAXC];
    logic [15:0]     mem_m   [32];
    int              rr_m;

    task automatic clear_exp(input int from);
        for (int c = from; c < MAXC; c++) begin
            x_grant[c] = '0;
            x_sop[c]   = '0;
            x_saddr[c] = '0;
            x_sdata[c] = '0;
            x_sdone[c] = '0;
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++)
            mem_m[i] = {2'b00, 5'(i), 1'b1, 2'b00, 5'(i), 1'b0};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Transaction timeline, with grant first visible in cycle e.
    function automatic void sched(input int k, input int op, input logic [4:0] a,
                                  input logic [15:0] d, input int e, input int fk,
                                  input int foff, input logic [15:0] fd,
                                  output int last, output int dn);
        logic [15:0] sd;
        sd = '0;
        if (op == OP_FLUSH) begin
            dn = e + 1;
            mem_m[a] = d;
        end else if (op == OP_UPGR) begin
            dn = e + 2;
        end else if (op == OP_RD || op == OP_RDX) begin
            if (fk >= 0) begin
                dn = e + foff + 1;
                sd = fd;
                mem_m[a] = fd;
            end else begin
                dn = e + 3 + SW + ML;
                sd = mem_m[a];
            end
        end else begin
            dn = -1;
        end
        last = (dn >= 0) ? dn : e + TO - 1;
        for (int c = e; c <= last; c++) x_grant[c] = NC'(1) << k;
        if (op == OP_UPGR || op == OP_RD || op == OP_RDX) begin
            for (int j = 0; j < NC; j++)
                if (j != k) x_sop[e+1][3*j +: 3] = 3'(op);
            x_saddr[e+1] = a;
        end
        if (dn >= 0) begin
            x_sdone[dn] = NC'(1) << k;
            x_saddr[dn] = a;
            x_sdata[dn] = sd;
        end
        rr_m = (k + 1) % NC;
    endfunction

    task automatic do_txn(input int k, input int op, input logic [4:0] a, input logic [15:0] d,
                          input int fk, input int foff, input logic [15:0] fd,
                          input logic [15:0] lit);
        int e, last, dn;
        e = cyc + 1;
        sched(k, op, a, d, e, fk, foff, fd, last, dn);
        bus.req[k] = 1'b1;
        @(negedge clk);
        bus.req[k] = 1'b0;
        bus.c_op[3*k +: 3]    = 3'(op);
        bus.c_addr[5*k +: 5]  = a;
        bus.c_data[16*k +: 16] = d;
        @(negedge clk);
        bus.c_op[3*k +: 3] = '0;
        if (fk >= 0) begin
            while (cyc < e + foff) @(negedge clk);
            bus.c_done[fk] = 1'b1;
            bus.c_op[3*fk +: 3]     = 3'(OP_FLUSH);
            bus.c_addr[5*fk +: 5]   = a;
            bus.c_data[16*fk +: 16] = fd;
            @(negedge clk);
            bus.c_done[fk] = 1'b0;
            bus.c_op[3*fk +: 3] = '0;
        end
        if (dn >= 0) begin
            while (cyc < dn) @(negedge clk);
            chk("done_data", 32'(bus.s_data), 32'(lit));
            chk("done_bit", 32'(bus.s_done), 32'(NC'(1) << k));
        end else begin
            while (cyc < e + TO) @(negedge clk);
            chk("timeout_grant", 32'(bus.grant), 32'd0);
        end
        while (cyc < last + 2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            n_chk++;
            if (bus.grant !== x_grant[cyc] || bus.s_op !== x_sop[cyc] ||
                bus.s_addr !== x_saddr[cyc] || bus.s_data !== x_sdata[cyc] ||
                bus.s_done !== x_sdone[cyc]) begin
                n_err++;
                $display("FAIL outputs cycle %0d: grant %b/%b s_op %h/%h s_addr %h/%h s_data %h/%h s_done %b/%b (got/want)",
                         cyc, bus.grant, x_grant[cyc], bus.s_op, x_sop[cyc], bus.s_addr,
                         x_saddr[cyc], bus.s_data, x_sdata[cyc], bus.s_done, x_sdone[cyc]);
            end
        end
    end

    initial begin
        int e, last, dn;
        logic [NC-1:0] rr_lit [3];
        rr_lit[0] = 2'b01;
        rr_lit[1] = 2'b10;
        rr_lit[2] = 2'b01;
        bus.req = '0;
        bus.c_op = '0;
        bus.c_addr = '0;
        bus.c_data = '0;
        bus.c_done = '0;
        clear_exp(0);
        init_mem();
        rr_m = 0;

        @(negedge clk);
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_done", 32'(bus.s_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_txn(0, OP_RD, 5'h0A, 16'h0, -1, 0, 16'h0, 16'h1514);
        do_txn(0, OP_RD, 5'h0A, 16'h0, 1, 1 + SW, 16'hBEEF, 16'hBEEF);
        do_txn(1, OP_RD, 5'h0A, 16'h0, -1, 0, 16'h0, 16'hBEEF);
        do_txn(1, OP_FLUSH, 5'h1F, 16'h1234, -1, 0, 16'h0, 16'h0000);
        do_txn(0, OP_RDX, 5'h1F, 16'h0, -1, 0, 16'h0, 16'h1234);
        do_txn(1, OP_UPGR, 5'h02, 16'h0, -1, 0, 16'h0, 16'h0000);

        // Both caches hold req with an upgrade pending; grants must alternate.
        e = cyc + 1;
        bus.req = 2'b11;
        bus.c_op = {3'(OP_UPGR), 3'(OP_UPGR)};
        bus.c_addr = {5'h02, 5'h01};
        for (int i = 0; i < 3; i++) begin
            sched(rr_m, OP_UPGR, (rr_m == 0) ? 5'h01 : 5'h02, 16'h0, e, -1, 0, 16'h0, last, dn);
            while (cyc < e) @(negedge clk);
            chk("rr_grant", 32'(bus.grant), 32'(rr_lit[i]));
            if (i == 2) bus.req = '0;
            e = last + 3;
        end
        while (cyc < last + 2) @(negedge clk);
        bus.c_op = '0;
        bus.c_addr = '0;

        do_txn(0, OP_NONE, 5'h05, 16'h0, -1, 0, 16'h0, 16'h0);

        // Reset in the middle of a memory read.
        e = cyc + 1;
        sched(0, OP_RD, 5'h0A, 16'h0, e, -1, 0, 16'h0, last, dn);
        bus.req[0] = 1'b1;
        @(negedge clk);
        bus.req[0] = 1'b0;
        bus.c_op[2:0] = 3'(OP_RD);
        bus.c_addr[4:0] = 5'h0A;
        @(negedge clk);
        bus.c_op[2:0] = '0;
        while (cyc < e + 5) @(negedge clk);
        reset = 1'b1;
        clear_exp(cyc + 1);
        init_mem();
        rr_m = 0;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        chk("midrst_done", 32'(bus.s_done), 32'd0);
        chk("midrst_data", 32'(bus.s_data), 32'd0);
        @(negedge clk);

        do_txn(0, OP_RD, 5'h03, 16'h0, -1, 0, 16'h0, 16'h0706);
        do_txn(0, OP_RD, 5'h0A, 16'h0, -1, 0, 16'h0, 16'h1514);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
